// File: rtl/ntt_pkg.sv
// Shared constants, bank-state encoding and the index bit-reversal helper
// for the NTT output path.
package ntt_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned N          = 1 << ADDR_WIDTH;
  localparam int unsigned MODULO     = 7681;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FULL     = 2'd1,
    BANK_DRAINING = 2'd2
  } bank_state_e;

  // Reverse the low 'width' bits of idx.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
    int unsigned r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r = (r << 1) | ((idx >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bitrev_reorder_if.sv
// Stream bundle for the bit-reverse reorder buffer.
//   din/din_valid/din_ready       : bit-reversed input stream (from sdf_top)
//   dout/dout_valid/dout_ready    : natural-order output stream
//   dout_first/dout_last          : frame index 0 / N-1 markers on dout
//   done_tick                     : pulse after the last word of a frame is taken
// slave = reorder buffer, master = producer/consumer environment.
interface ntt_bitrev_reorder_if
  import ntt_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH
);
  logic [data_width-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [data_width-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_first;
  logic                  dout_last;
  logic                  done_tick;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_first, dout_last, done_tick
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_first, dout_last, done_tick
  );
endinterface

// File: rtl/ntt_reorder_bank.sv
// One frame of storage: 2**addr_width words, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module ntt_reorder_bank
  import ntt_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned addr_width = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [1 << addr_width];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts an N-point NTT result in bit-reversed
// order and emits it in natural order. One bank fills while the other
// drains, sustaining one word per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of ntt_bitrev_reorder_if (its data_width must match)
module ntt_bitrev_reorder
  import ntt_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned addr_width = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ntt_bitrev_reorder_if.slave   bus
);

  typedef logic [addr_width-1:0] addr_t;

  bank_state_e           state_q [2];
  logic                  wr_bank_q, rd_bank_q;
  addr_t                 wr_cnt_q, rd_cnt_q;
  logic [data_width-1:0] dout_q;
  logic                  dout_valid_q, dout_first_q, dout_last_q, done_q;

  logic                  din_ready;
  logic                  wr_fire, rd_load;
  addr_t                 wr_addr;
  logic [data_width-1:0] rdata0, rdata1, rd_word;

  // Only registered bank state feeds din_ready; no path from dout_ready.
  assign din_ready = (state_q[wr_bank_q] == BANK_EMPTY);
  assign wr_fire   = bus.din_valid && din_ready;
  assign wr_addr   = addr_t'(bitrev(32'(wr_cnt_q), addr_width));
  assign rd_word   = rd_bank_q ? rdata1 : rdata0;
  assign rd_load   = (!dout_valid_q || bus.dout_ready) &&
                     (state_q[rd_bank_q] != BANK_EMPTY);

  ntt_reorder_bank #(.data_width(data_width), .addr_width(addr_width)) u_bank0 (
    .clk     (clk),
    .we_i    (wr_fire && !wr_bank_q),
    .waddr_i (wr_addr),
    .wdata_i (bus.din),
    .raddr_i (rd_cnt_q),
    .rdata_o (rdata0)
  );

  ntt_reorder_bank #(.data_width(data_width), .addr_width(addr_width)) u_bank1 (
    .clk     (clk),
    .we_i    (wr_fire && wr_bank_q),
    .waddr_i (wr_addr),
    .wdata_i (bus.din),
    .raddr_i (rd_cnt_q),
    .rdata_o (rdata1)
  );

  // Write completion and read release never touch the same bank in one
  // cycle: the write bank is EMPTY, the read bank is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]   <= BANK_EMPTY;
      state_q[1]   <= BANK_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt_q == '1) begin
          wr_cnt_q           <= '0;
          state_q[wr_bank_q] <= BANK_FULL;
          wr_bank_q          <= !wr_bank_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end

      if (rd_load) begin
        dout_q       <= rd_word;
        dout_first_q <= (rd_cnt_q == '0);
        dout_last_q  <= (rd_cnt_q == '1);
        dout_valid_q <= 1'b1;
        if (rd_cnt_q == '1) begin
          rd_cnt_q           <= '0;
          state_q[rd_bank_q] <= BANK_EMPTY;
          rd_bank_q          <= !rd_bank_q;
        end else begin
          rd_cnt_q           <= rd_cnt_q + 1'b1;
          state_q[rd_bank_q] <= BANK_DRAINING;
        end
      end else if (bus.dout_ready && dout_valid_q) begin
        dout_valid_q <= 1'b0;
      end

      done_q <= dout_valid_q && bus.dout_ready && dout_last_q;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_first = dout_first_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.done_tick  = done_q;

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
module tb_ntt_bitrev_reorder;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  ntt_bitrev_reorder_if #(.data_width(DATA_WIDTH)) bus ();

  ntt_bitrev_reorder #(.data_width(DATA_WIDTH), .addr_width(ADDR_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp_dout;
    logic        exp_first;
    logic        exp_last;
  } vec_t;

  vec_t vecs [16];
  int unsigned exp_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: captures accepted input beats, builds the natural-order
  // frame, and checks every accepted output word plus hold/done behaviour.
  logic [63:0] exp_q [$];
  logic [63:0] nat [16];
  int unsigned in_cnt = 0;
  int unsigned out_cnt = 0;
  logic        done_exp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_dout;
  logic        prev_first, prev_last;

  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      exp_q.delete();
      in_cnt     = 0;
      out_cnt    = 0;
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_tick", bus.done_tick, done_exp);
      if (prev_stall) begin
        chk("hold dout", bus.dout, prev_dout);
        chk("hold dout_valid", bus.dout_valid, 1);
        chk("hold dout_first", bus.dout_first, prev_first);
        chk("hold dout_last", bus.dout_last, prev_last);
      end
      if (bus.din_valid && bus.din_ready) begin
        nat[bitrev(in_cnt, ADDR_WIDTH)] = bus.din;
        in_cnt++;
        if (in_cnt == 16) begin
          for (int i = 0; i < 16; i++) exp_q.push_back(nat[i]);
          in_cnt = 0;
        end
      end
      done_exp = 1'b0;
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious dout_valid", bus.dout_valid, 0);
        end else begin
          chk("dout order", bus.dout, exp_q.pop_front());
        end
        chk("dout_first", bus.dout_first, out_cnt == 0);
        chk("dout_last", bus.dout_last, out_cnt == 15);
        done_exp = (out_cnt == 15);
        out_cnt  = (out_cnt + 1) % 16;
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      prev_first = bus.dout_first;
      prev_last  = bus.dout_last;
    end
  end

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.dout_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.dout_valid) begin
      errors++;
      $display("FAIL %s drain: %0d words pending, required 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sent;
    int unsigned iter;
    logic fired;

    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset dout", bus.dout, 0);
    chk("reset dout_valid", bus.dout_valid, 0);
    chk("reset din_ready", bus.din_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset din_ready", bus.din_ready, 1);
    chk("post-reset dout_valid", bus.dout_valid, 0);
    chk("post-reset done_tick", bus.done_tick, 0);

    // Table-driven single frame
    for (int k = 0; k < 16; k++) begin
      vecs[k].din       = 64'(k);
      vecs[k].exp_dout  = 64'(exp_order[k]);
      vecs[k].exp_first = (k == 0);
      vecs[k].exp_last  = (k == 15);
    end
    for (int k = 0; k < 16; k++) begin
      bus.din       = vecs[k].din;
      bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    chk("latency: not valid right after last beat", bus.dout_valid, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("table dout", bus.dout, vecs[k].exp_dout);
      chk("table dout_valid", bus.dout_valid, 1);
      chk("table dout_first", bus.dout_first, vecs[k].exp_first);
      chk("table dout_last", bus.dout_last, vecs[k].exp_last);
    end
    @(negedge clk);
    chk("table done_tick", bus.done_tick, 1);
    chk("table valid after frame", bus.dout_valid, 0);
    @(negedge clk);
    chk("table done_tick one cycle", bus.done_tick, 0);

    // Three back-to-back frames, full throughput
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int k = 0; k < 16; k++) begin
            chk("b2b din_ready", bus.din_ready, 1);
            bus.din       = 64'(100 * f + k);
            bus.din_valid = 1'b1;
            @(negedge clk);
          end
        end
        bus.din_valid = 1'b0;
      end
      begin
        int unsigned w = 0;
        while (!bus.dout_valid && w < 40) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 48; i++) begin
          chk("b2b gapless dout_valid", bus.dout_valid, 1);
          @(negedge clk);
        end
      end
    join
    wait_drain("b2b");

    // Backpressure: both banks fill, then release
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("bp din_ready before full", bus.din_ready, 1);
      bus.din       = 64'(300 + i);
      bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    chk("bp din_ready at beat 32", bus.din_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp din_ready held low", bus.din_ready, 0);
    chk("bp stalled dout", bus.dout, 300);
    chk("bp stalled dout_first", bus.dout_first, 1);
    bus.dout_ready = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      chk("bp din_ready during drain", bus.din_ready, e == 15);
    end
    wait_drain("backpressure");

    // Random valid gaps and ready stalls
    sent = 0;
    iter = 0;
    while (sent < 48 && iter < 3000) begin
      bus.din        = 64'($urandom_range(0, MODULO - 1));
      bus.din_valid  = ($urandom_range(0, 2) != 0);
      bus.dout_ready = ($urandom_range(0, 2) != 0);
      fired = bus.din_valid && bus.din_ready;
      @(negedge clk);
      if (fired) sent++;
      iter++;
    end
    checks++;
    if (sent < 48) begin
      errors++;
      $display("FAIL random feed: accepted %0d beats, required 48", sent);
    end
    wait_drain("random");

    // Asynchronous reset mid-frame with a stalled output word
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 23; i++) begin
      bus.din       = 64'(500 + i);
      bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    chk("pre-reset dout_valid", bus.dout_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dout", bus.dout, 0);
    chk("async reset dout_valid", bus.dout_valid, 0);
    chk("async reset dout_first", bus.dout_first, 0);
    chk("async reset din_ready", bus.din_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.din       = 64'(700 + k);
      bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    @(negedge clk);
    chk("after reset first word", bus.dout, 700);
    chk("after reset first flag", bus.dout_first, 1);
    @(negedge clk);
    chk("after reset second word", bus.dout, 708);
    wait_drain("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_bitrev_reorder.md
# ntt_bitrev_reorder

Reorder buffer placed directly downstream of `sdf_top`. It receives the 16-point NTT result stream, which arrives one coefficient per accepted beat in bit-reversed index order. It emits the same coefficients in natural order. Two ping-pong banks let one frame fill while the previous frame drains, so a continuous stream sustains one word per cycle.

## Interface
Parameters:
- `data_width`, 64, coefficient word width; must match `sdf_top`.
- `addr_width`, 4, log2 of frame length N (N = 2**addr_width = 16).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  data_width  coefficient from `sdf_out`.
- `din_valid`  in  1  `din` valid this cycle.
- `din_ready`  out  1  buffer can accept `din`; beat transfers when valid&&ready.
- `dout`  out  data_width  natural-order coefficient.
- `dout_valid`  out  1  `dout` valid.
- `dout_ready`  in  1  consumer accepts `dout`.
- `dout_first`  out  1  `dout` is index 0 of a frame.
- `dout_last`  out  1  `dout` is index N-1 of a frame.
- `done_tick`  out  1  one-cycle pulse after the last word of a frame is accepted.

## Operation
- Two banks, 0 and 1, of N words each. Each bank has a state: EMPTY, FULL, or DRAINING. Filling is implied by wr_bank pointing at an EMPTY bank.
- Write side: registers `wr_bank` (reset 0) and `wr_cnt` (addr_width bits, reset 0).
  - `din_ready` = (state[wr_bank] == EMPTY). It is decoded from registered state only, never from `dout_ready`.
  - On accept: bank[wr_bank][bitrev(wr_cnt)] <= din; wr_cnt++.
  - On accept with wr_cnt == N-1: state[wr_bank] <= FULL, wr_bank toggles, wr_cnt <= 0.
  - Gaps in `din_valid` mid-frame are allowed and hold the counters.
- Read side: registers `rd_bank` (reset 0) and `rd_cnt` (reset 0), plus an output register (dout/first/last/valid).
  - Load condition: (!dout_valid || dout_ready) && state[rd_bank] ∈ {FULL, DRAINING}.
  - On load: dout <= bank[rd_bank][rd_cnt]; dout_first <= (rd_cnt == 0); dout_last <= (rd_cnt == N-1); dout_valid <= 1; state <= DRAINING; rd_cnt++.
  - On load with rd_cnt == N-1: state[rd_bank] <= EMPTY, rd_bank toggles, rd_cnt <= 0.
  - If the load condition fails and dout_ready && dout_valid: dout_valid <= 0.
- `done_tick` <= dout_valid && dout_ready && dout_last (registered).
- bitrev reverses the addr_width-bit index. For addr_width = 4: 1→8, 2→4, 3→12, 6→6.
- Data is passed unmodified; no modular arithmetic is performed. Values are already reduced mod 7681 upstream.

## Timing
- Reset (asynchronous, any time, including mid-frame): both banks EMPTY, all pointers and counters 0, `dout` = 0, `dout_valid`/`first`/`last`/`done_tick` = 0. `din_ready` = 1 in the first cycle after deassertion. Partial frames are discarded. Bank contents need not be cleared.
- Latency: last input beat accepted at edge t → `dout_valid` with `dout_first` after edge t+1.
- Throughput: with dout_ready held at 1, a frame accepted at edges 0..15 is output at edges 16..31. The next frame is written to bank 1 at edges 16..31. Bank 0 is freed at edge 31, so din_ready stays 1 continuously.
- Both banks FULL/DRAINING → `din_ready` = 0 until the read side frees a bank. A freed bank is writable in the following cycle, never the same cycle.
- `dout` and its flags hold stable while dout_valid && !dout_ready.
- A write-side frame completion and a read-side bank release in the same cycle act on different banks and are independent.

## Structure
- Package `ntt_pkg`: DATA_WIDTH = 64, ADDR_WIDTH = 4, N, MODULO = 7681, bank-state encoding, and the `bitrev` function (shared with future `sdf_top` variants and benches).
- Sub-module `ntt_reorder_bank`: N×data_width register file with one write port and one asynchronous read port; instantiated twice. The top level holds the pointers, state, and output register.

## Test plan
- Single frame, din = k at beat k (k = 0..15), dout_ready = 1 → dout sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. dout_first on value 0, dout_last on 15, done_tick one cycle after the 15 beat. First dout_valid one cycle after the last input beat.
- Three back-to-back frames (values k, 100+k, 200+k), din_valid and dout_ready held at 1 → din_ready never drops and output is gapless for 48 cycles in the correct order.
- dout_ready = 0 while two frames are pushed → din_ready falls on beat 32. Releasing dout_ready drains 32 words in order, and din_ready rises the cycle after the first frame's last word is loaded.
- Random din_valid gaps and random dout_ready stalls → output matches the bitrev golden model from `expected_sdf_out.txt`. dout is held stable on every stalled cycle.
- rst_n asserted after 7 input beats → outputs 0 immediately. A new full frame after reset is reordered correctly with no residue from the aborted frame.
